// File: rtl/mw_pipe_reg_pkg.sv
// Shared pipeline-register constants: word width, reset/bubble values, MIPS instruction field ranges.
// Imported by the F/D, D/E, E/M and M/W registers.
package mw_pipe_reg_pkg;

  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  localparam word_t NOP_IR   = 32'h0000_0000;
  localparam word_t RESET_PC = 32'h0000_3000;

  localparam int OP_HI   = 31;
  localparam int OP_LO   = 26;
  localparam int RS_HI   = 25;
  localparam int RS_LO   = 21;
  localparam int RT_HI   = 20;
  localparam int RT_LO   = 16;
  localparam int RD_HI   = 15;
  localparam int RD_LO   = 11;
  localparam int FUNC_HI = 5;
  localparam int FUNC_LO = 0;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] func;
  } instr_t;

  function automatic logic [5:0] instr_op(input word_t ir);
    return ir[OP_HI:OP_LO];
  endfunction

endpackage

// File: rtl/mw_pipe_reg_if.sv
// M-to-W pipeline register bus: M-stage inputs plus stall/flush controls, and W-stage outputs.
// master drives the M side (memory stage), slave is the register itself.
interface mw_pipe_reg_if;
  import mw_pipe_reg_pkg::*;

  logic       en_M;
  logic       flush_M;
  logic       valid_M;
  word_t      IR_M;
  word_t      PC_M;
  word_t      ALU_M;
  word_t      DM_RD_M;
  word_t      HILO_M;
  word_t      CP0_RD_M;

  word_t      IR_W;
  word_t      PC_W;
  word_t      PC8_W;
  word_t      ALU_W;
  word_t      DM_RD_W;
  word_t      HILO_W;
  word_t      CP0_RD_W;
  logic [1:0] BYTE_OFF_W;
  logic       valid_W;
  logic       retire_W;

  modport master (
    output en_M, flush_M, valid_M, IR_M, PC_M, ALU_M, DM_RD_M, HILO_M, CP0_RD_M,
    input  IR_W, PC_W, PC8_W, ALU_W, DM_RD_W, HILO_W, CP0_RD_W, BYTE_OFF_W,
           valid_W, retire_W
  );

  modport slave (
    input  en_M, flush_M, valid_M, IR_M, PC_M, ALU_M, DM_RD_M, HILO_M, CP0_RD_M,
    output IR_W, PC_W, PC8_W, ALU_W, DM_RD_W, HILO_W, CP0_RD_W, BYTE_OFF_W,
           valid_W, retire_W
  );

endinterface

// File: rtl/mw_pipe_reg_pipe_field.sv
// One pipeline field: async reset value, then synchronous clear over enable-load.
// Latency 1 cycle; en=0 holds the stored value.
module mw_pipe_reg_pipe_field #(
  parameter int             W       = 32,
  parameter logic [W-1:0]   RST_VAL = '0,
  parameter logic [W-1:0]   CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/mw_pipe_reg.sv
// M/W pipeline register: one-cycle M->W, stall holds W (no re-retire), flush inserts a NOP bubble.
// Optional retired-instruction counter on output retire_cnt when MW_RETIRE_CNT_EN is defined.
module mw_pipe_reg
  import mw_pipe_reg_pkg::*;
#(
  parameter word_t P_RESET_PC = RESET_PC,
  parameter word_t P_NOP_IR   = NOP_IR
) (
  input  logic  clk,
  input  logic  reset,
  mw_pipe_reg_if.slave mw
`ifdef MW_RETIRE_CNT_EN
  ,
  output word_t retire_cnt
`endif
);

  logic load_valid;
  assign load_valid = mw.en_M & ~mw.flush_M & mw.valid_M;

  mw_pipe_reg_pipe_field #(.W(WORD_W), .RST_VAL(P_NOP_IR), .CLR_VAL(P_NOP_IR)) u_ir (
    .clk(clk), .reset(reset), .clr(mw.flush_M), .en(mw.en_M), .d(mw.IR_M), .q(mw.IR_W)
  );

  // A bubble still carries the M-stage address so exceptions stay traceable.
  mw_pipe_reg_pipe_field #(.W(WORD_W), .RST_VAL(P_RESET_PC), .CLR_VAL('0)) u_pc (
    .clk(clk), .reset(reset), .clr(1'b0), .en(mw.en_M | mw.flush_M), .d(mw.PC_M), .q(mw.PC_W)
  );

  mw_pipe_reg_pipe_field #(.W(WORD_W)) u_alu (
    .clk(clk), .reset(reset), .clr(mw.flush_M), .en(mw.en_M), .d(mw.ALU_M), .q(mw.ALU_W)
  );

  mw_pipe_reg_pipe_field #(.W(WORD_W)) u_dm (
    .clk(clk), .reset(reset), .clr(mw.flush_M), .en(mw.en_M), .d(mw.DM_RD_M), .q(mw.DM_RD_W)
  );

  mw_pipe_reg_pipe_field #(.W(WORD_W)) u_hilo (
    .clk(clk), .reset(reset), .clr(mw.flush_M), .en(mw.en_M), .d(mw.HILO_M), .q(mw.HILO_W)
  );

  mw_pipe_reg_pipe_field #(.W(WORD_W)) u_cp0 (
    .clk(clk), .reset(reset), .clr(mw.flush_M), .en(mw.en_M), .d(mw.CP0_RD_M), .q(mw.CP0_RD_W)
  );

  mw_pipe_reg_pipe_field #(.W(1)) u_valid (
    .clk(clk), .reset(reset), .clr(mw.flush_M), .en(mw.en_M), .d(mw.valid_M), .q(mw.valid_W)
  );

  // Reloaded every edge so a held instruction pulses only once.
  mw_pipe_reg_pipe_field #(.W(1)) u_retire (
    .clk(clk), .reset(reset), .clr(1'b0), .en(1'b1), .d(load_valid), .q(mw.retire_W)
  );

  assign mw.PC8_W      = mw.PC_W + 32'd8;
  assign mw.BYTE_OFF_W = mw.ALU_W[1:0];

`ifdef MW_RETIRE_CNT_EN
  word_t retire_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_cnt_q <= '0;
    end else if (load_valid) begin
      retire_cnt_q <= retire_cnt_q + 32'd1;
    end
  end

  assign retire_cnt = retire_cnt_q;
`endif

endmodule

// File: doc/mw_pipe_reg.md
Name: mw_pipe_reg

Overview:
- M/W pipeline register between the memory stage and the write-back stage of the 5-stage MIPS core.
- Captures the instruction word and its datapath results at the end of M.
- Presents them to the W-stage control decoder and the write-back mux/extender.
- Handles stall and flush (bubble) requests, tracks instruction validity, and emits a one-cycle retire pulse per completed instruction.

Parameters:
- RESET_PC, 32'h0000_3000, value of PC_W after reset
- NOP_IR, 32'h0000_0000, instruction word inserted on reset/flush (sll $0,$0,0)

Ports:
- clk  in  1  core clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- en_M  in  1  advance enable; 0 = stall (hold W contents)
- flush_M  in  1  insert bubble into W (exception/eret)
- valid_M  in  1  M-stage slot holds a real instruction
- IR_M  in  32  M-stage instruction word
- PC_M  in  32  M-stage instruction address
- ALU_M  in  32  ALU result / effective address
- DM_RD_M  in  32  raw data-memory read word (unaligned, unextended)
- HILO_M  in  32  HI or LO read value for mfhi/mflo
- CP0_RD_M  in  32  CP0 read value for mfc0
- IR_W  out  32  W-stage instruction word (to W decoder)
- PC_W  out  32  W-stage instruction address
- PC8_W  out  32  PC_W + 8 (link value for jal/jalr)
- ALU_W  out  32  registered ALU result
- DM_RD_W  out  32  registered memory word
- HILO_W  out  32  registered HI/LO value
- CP0_RD_W  out  32  registered CP0 value
- BYTE_OFF_W  out  2  ALU_W[1:0], byte lane for the load extender
- valid_W  out  1  W slot holds a real instruction
- retire_W  out  1  one-cycle pulse, instruction entered W this cycle

Behaviour:
- Async reset, effective immediately and independent of clk:
  - IR_W=NOP_IR, PC_W=RESET_PC.
  - ALU_W, DM_RD_W, HILO_W and CP0_RD_W are 0.
  - valid_W=0, retire_W=0.
- Per-edge priority is reset > flush > stall > load.
- Flush (flush_M=1, regardless of en_M):
  - IR_W<=NOP_IR, valid_W<=0, retire_W<=0.
  - PC_W<=PC_M, so the bubble keeps a traceable address.
  - Data fields <= 0.
- Stall (flush_M=0, en_M=0):
  - All fields and valid_W hold.
  - retire_W<=0, so a held instruction never retires twice.
- Load (flush_M=0, en_M=1):
  - Every field <= its M counterpart.
  - valid_W<=valid_M, retire_W<=valid_M.
- Latency: one cycle M to W. No combinational path from any *_M input to any output.
- PC8_W and BYTE_OFF_W are combinational from the registered PC_W/ALU_W.
  - PC8_W addition wraps mod 2^32 (PC_W=32'hFFFF_FFFC gives 32'h0000_0004).
- When valid_M=0 on a load, the fields are still captured verbatim.
  - Downstream write enable must be qualified by valid_W.
  - IR_W is not forced to NOP.
- Reset asserted mid-stall or mid-flush wins immediately. The first edge after reset release follows the normal priority.
- Simultaneous flush_M and en_M=0: flush wins and the bubble is inserted.

Optional Feature:
- Macro MW_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt [31:0], reset to 0.
  - Increments by 1 on every edge where retire_W is being set to 1.
  - Wraps 32'hFFFF_FFFF to 0; never changes on stall or flush.
- When undefined: the port and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/header holds:
  - instruction field ranges (op 31:26, rs 25:21, rt 20:16, rd 15:11, func 5:0);
  - NOP_IR and RESET_PC constants;
  - the 32-bit word width constant.
  These are shared with the F/D, D/E and E/M registers.
- One natural sub-module: pipe_field, a width-parameterised register with async reset value, synchronous clear value, clear and enable. It is instantiated once per field.

Test Plan:
- Reset mid-operation: reset=1 with arbitrary inputs -> IR_W=0, PC_W=32'h3000, PC8_W=32'h3008, valid_W=0, all data fields 0, without waiting for clk.
- Normal load: IR_M=32'h8C43_0004 (lw), PC_M=32'h3010, ALU_M=32'h0000_1006, valid_M=1, en_M=1 -> next cycle IR_W=32'h8C43_0004, PC8_W=32'h3018, BYTE_OFF_W=2, retire_W=1 for exactly one cycle.
- Stall: load as above, then en_M=0 for 3 cycles with changed inputs -> W fields unchanged, valid_W=1, retire_W=0 in all 3 cycles.
- Flush during stall: en_M=0, flush_M=1, PC_M=32'h3020 -> IR_W=0, valid_W=0, PC_W=32'h3020, retire_W=0.
- Wrap and invalid slot:
  - PC_M=32'hFFFF_FFFC -> PC8_W=32'h0000_0004.
  - valid_M=0 with IR_M=32'h0062_2021 -> IR_W=32'h0062_2021, valid_W=0, retire_W=0.
- With MW_RETIRE_CNT_EN: 5 valid loads, 2 stalls, 1 flush -> retire_cnt=5. Preload 32'hFFFF_FFFF by force, one retire -> 0.
